// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative floating-point multiplier with start/done handshake.
// Sequence: IDLE -> LOAD -> MUL (N shift-add cycles) -> NORM -> RND -> DONE.
// Denormal operands are flushed to zero. The result exponent saturates to Inf
// on overflow and flushes to zero on underflow.
// Optional macro FP_MUL_RNE_EN: round-to-nearest-even when defined,
// truncation toward zero when undefined. Latency is the same in both builds.
module fp_mul_iter #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_sig,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done_sig,
  output logic                 busy,
  output logic [2:0]           flags
);

  localparam int W      = EXP_W + MAN_W + 1;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int N      = SIG_W / STEP_BITS;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int EW     = EXP_W + 2;
  localparam int PP_W   = SIG_W + STEP_BITS;

  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_NORM, S_RND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [EW-1:0]      exp_q, exp_d;
  logic [SIG_W-1:0]   acc_q, acc_d;     // upper half of the running product
  logic [SIG_W-1:0]   mplier_q, mplier_d; // multiplier digits, refilled with low product bits
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAN_W-1:0]   frac_q, frac_d;
  logic [W-1:0]       pend_res_q, pend_res_d;
  logic [2:0]         pend_flg_q, pend_flg_d;
  logic [W-1:0]       result_q, result_d;
  logic [2:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef FP_MUL_RNE_EN
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
`endif

  // Operand field decode from the latched operands.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;
  assign ea      = a_q[W-2 -: EXP_W];
  assign eb      = b_q[W-2 -: EXP_W];
  assign fa      = a_q[MAN_W-1:0];
  assign fb      = b_q[MAN_W-1:0];
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_nan   = (&ea) & (|fa);
  assign b_nan   = (&eb) & (|fb);
  assign a_inf   = (&ea) & ~(|fa);
  assign b_inf   = (&eb) & ~(|fb);
  assign sign_ab = a_q[W-1] ^ b_q[W-1];

  // One shift-add step: upper product half plus multiplicand times the next digit.
  logic [PP_W-1:0] mcand_ext, step_sum;
  always_comb begin
    mcand_ext = {{STEP_BITS{1'b0}}, 1'b1, fa};
    step_sum  = {{STEP_BITS{1'b0}}, acc_q};
    for (int k = 0; k < STEP_BITS; k++) begin
      if (mplier_q[k]) step_sum = step_sum + (mcand_ext << k);
    end
  end

  // Rounding of the normalised fraction; a carry out bumps the exponent.
  logic [EW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
`ifdef FP_MUL_RNE_EN
  logic             round_up;
  logic [MAN_W:0]   frac_sum;
  always_comb begin
    round_up = guard_q & (sticky_q | frac_q[0]);
    frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_up};
    frac_r   = frac_sum[MAN_W-1:0];
    exp_r    = exp_q + {{(EW-1){1'b0}}, frac_sum[MAN_W]};
  end
`else
  always_comb begin
    frac_r = frac_q;
    exp_r  = exp_q;
  end
`endif

  logic ovf, unf;
  assign ovf = ~exp_r[EW-1] & (exp_r >= EXP_MAX);
  assign unf = exp_r[EW-1] | (exp_r == '0);

  // Next-state and datapath update for every FSM state.
  logic [PROD_W-1:0] prod;
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    frac_d     = frac_q;
    pend_res_d = pend_res_q;
    pend_flg_d = pend_flg_q;
    result_d   = result_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    prod       = {acc_q, mplier_q};
`ifdef FP_MUL_RNE_EN
    guard_d    = guard_q;
    sticky_d   = sticky_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = start_sig;
        if (start_sig) begin
          a_d     = A;
          b_d     = B;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sign_d = sign_ab;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
          pend_res_d = QNAN;
          pend_flg_d = 3'b100;
          state_d    = S_DONE;
        end else if (a_inf | b_inf) begin
          pend_res_d = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          pend_flg_d = 3'b000;
          state_d    = S_DONE;
        end else if (a_zero | b_zero) begin
          pend_res_d = {sign_ab, {(W-1){1'b0}}};
          pend_flg_d = 3'b000;
          state_d    = S_DONE;
        end else begin
          acc_d    = '0;
          mplier_d = {1'b1, fb};
          exp_d    = {2'b00, ea} + {2'b00, eb} - BIAS;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = step_sum[PP_W-1:STEP_BITS];
        mplier_d = {step_sum[STEP_BITS-1:0], mplier_q[SIG_W-1:STEP_BITS]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N-1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (prod[PROD_W-1]) begin
          frac_d   = prod[PROD_W-2 -: MAN_W];
          exp_d    = exp_q + EW'(1);
`ifdef FP_MUL_RNE_EN
          guard_d  = prod[MAN_W];
          sticky_d = |prod[MAN_W-1:0];
`endif
        end else begin
          frac_d   = prod[PROD_W-3 -: MAN_W];
`ifdef FP_MUL_RNE_EN
          guard_d  = prod[MAN_W-1];
          sticky_d = |prod[MAN_W-2:0];
`endif
        end
        state_d = S_RND;
      end
      S_RND: begin
        if (ovf) begin
          pend_res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          pend_flg_d = 3'b010;
        end else if (unf) begin
          pend_res_d = {sign_q, {(W-1){1'b0}}};
          pend_flg_d = 3'b001;
        end else begin
          pend_res_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          pend_flg_d = 3'b000;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d = pend_res_q;
        flags_d  = pend_flg_q;
        done_d   = 1'b1;
        busy_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      frac_q     <= '0;
      pend_res_q <= '0;
      pend_flg_q <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FP_MUL_RNE_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      frac_q     <= frac_d;
      pend_res_q <= pend_res_d;
      pend_flg_q <= pend_flg_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef FP_MUL_RNE_EN
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

  assign result   = result_q;
  assign flags    = flags_q;
  assign done_sig = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Testbench for fp_mul_iter: directed cases plus random operands checked
// against an arithmetic single-precision reference model.
module tb_fp_mul_iter;

  logic        clk;
  logic        rst;
  logic        start_sig, start4;
  logic [31:0] A, B;
  logic [31:0] result, result4;
  logic        done_sig, done4, busy, busy4;
  logic [2:0]  flags, flags4;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_iter #(.EXP_W(8), .MAN_W(23), .STEP_BITS(1)) dut (
    .clk(clk), .rst(rst), .start_sig(start_sig), .A(A), .B(B),
    .result(result), .done_sig(done_sig), .busy(busy), .flags(flags)
  );

  fp_mul_iter #(.EXP_W(8), .MAN_W(23), .STEP_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .start_sig(start4), .A(A), .B(B),
    .result(result4), .done_sig(done4), .busy(busy4), .flags(flags4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product of the significands, then rounding
  // decided by comparing the discarded remainder against one half ulp.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, an, bn, ai, bi, az, bz;
    int          ea, eb, e, sh;
    logic [63:0] p, m;
`ifdef FP_MUL_RNE_EN
    logic [63:0] rem, half;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 23'h0);
    bn = (eb == 255) && (b[22:0] != 23'h0);
    ai = (ea == 255) && (a[22:0] == 23'h0);
    bi = (eb == 255) && (b[22:0] == 23'h0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC00000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz) return {3'b000, s, 31'h0};
    p = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    m = p >> sh;
`ifdef FP_MUL_RNE_EN
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
`endif
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], m[22:0]};
  endfunction

  // Present operands and a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
  endtask

  // Edges from acceptance to the done pulse of the default instance; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done_sig) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_sig = 1'b0;
    start4 = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=%b", flags, 3'b000); end
    n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_sig); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    $display("reset released: result=%h flags=%b done=%b busy=%b", result, flags, done_sig, busy);
  endtask

  task automatic test_basic();
    int cyc;
    launch(32'h40200000, 32'h40A00000);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    wait_done(cyc);
    $display("op 40200000 x 40A00000 -> %h flags=%b cycles=%0d", result, flags, cyc);
    n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL basic_latency got=%0d exp=28", cyc); end
    n_cmp++; if (result !== 32'h41480000) begin n_err++; $display("FAIL basic_result got=%h exp=41480000", result); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL basic_flags got=%b exp=000", flags); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (done_sig !== 1'b0) begin n_err++; $display("FAIL basic_done_width got=%b exp=0", done_sig); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    n_cmp++; if (result !== 32'h41480000) begin n_err++; $display("FAIL basic_result_hold got=%h exp=41480000", result); end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    A = 32'hBFC00000;
    B = 32'h40000000;
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc1);
    $display("op BFC00000 x 40000000 -> %h flags=%b cycles=%0d", result, flags, cyc1);
    n_cmp++; if (cyc1 !== 28) begin n_err++; $display("FAIL b2b_latency1 got=%0d exp=28", cyc1); end
    n_cmp++; if (result !== 32'hC0400000) begin n_err++; $display("FAIL b2b_result1 got=%h exp=C0400000", result); end
    A = 32'h3F800000;
    B = 32'h3F800000;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_done(cyc2);
    $display("op 3F800000 x 3F800000 -> %h flags=%b cycles=%0d", result, flags, cyc2);
    n_cmp++; if (cyc2 !== 28) begin n_err++; $display("FAIL b2b_latency2 got=%0d exp=28", cyc2); end
    n_cmp++; if (result !== 32'h3F800000) begin n_err++; $display("FAIL b2b_result2 got=%h exp=3F800000", result); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [31:0] tr [7];
    logic [2:0]  tf [7];
    int          tl [7];
    int          cyc;
    ta[0] = 32'h7F800000; tb[0] = 32'h00000000; tr[0] = 32'h7FC00000; tf[0] = 3'b100; tl[0] = 2;
    ta[1] = 32'hFF800000; tb[1] = 32'h40000000; tr[1] = 32'hFF800000; tf[1] = 3'b000; tl[1] = 2;
    ta[2] = 32'h80000000; tb[2] = 32'h3F800000; tr[2] = 32'h80000000; tf[2] = 3'b000; tl[2] = 2;
    ta[3] = 32'h7F000000; tb[3] = 32'h7F000000; tr[3] = 32'h7F800000; tf[3] = 3'b010; tl[3] = 28;
    ta[4] = 32'h00800000; tb[4] = 32'h00800000; tr[4] = 32'h00000000; tf[4] = 3'b001; tl[4] = 28;
    ta[5] = 32'h3FC00000; tb[5] = 32'h3F800001; tf[5] = 3'b000; tl[5] = 28;
`ifdef FP_MUL_RNE_EN
    tr[5] = 32'h3FC00002;
`else
    tr[5] = 32'h3FC00001;
`endif
    ta[6] = 32'h7FC00001; tb[6] = 32'h3F800000; tr[6] = 32'h7FC00000; tf[6] = 3'b100; tl[6] = 2;
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i]);
      wait_done(cyc);
      $display("op %h x %h -> %h flags=%b cycles=%0d", ta[i], tb[i], result, flags, cyc);
      n_cmp++; if (result !== tr[i]) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, tr[i]); end
      n_cmp++; if (flags !== tf[i]) begin n_err++; $display("FAIL dir%0d_flags got=%b exp=%b", i, flags, tf[i]); end
      n_cmp++; if (cyc !== tl[i]) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, tl[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [34:0] exp_v;
    int          cyc, exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'h00;
        1: a[30:23] = 8'hFF;
        2: b[30:23] = 8'hFF;
        3: b[30:23] = 8'h00;
        default: ;
      endcase
      exp_v = ref_mul(a, b);
      exp_lat = (a[30:23] == 8'h00 || a[30:23] == 8'hFF ||
                 b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 2 : 28;
      launch(a, b);
      wait_done(cyc);
      $display("op %h x %h -> %h flags=%b cycles=%0d", a, b, result, flags, cyc);
      n_cmp++; if (result !== exp_v[31:0]) begin n_err++; $display("FAIL rand%0d_result got=%h exp=%h", i, result, exp_v[31:0]); end
      n_cmp++; if (flags !== exp_v[34:32]) begin n_err++; $display("FAIL rand%0d_flags got=%b exp=%b", i, flags, exp_v[34:32]); end
      n_cmp++; if (cyc !== exp_lat) begin n_err++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, cyc, exp_lat); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    launch(32'h40200000, 32'h40A00000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL abort_result got=%h exp=00000000", result); end
    n_cmp++; if (flags !== 3'b000) begin n_err++; $display("FAIL abort_flags got=%b exp=000", flags); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_sig) pulses++;
      @(posedge clk);
      #1;
    end
    $display("abort in MUL: done pulses after reset=%0d result=%h", pulses, result);
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    launch(32'h40200000, 32'h40A00000);
    wait_done(cyc);
    $display("op 40200000 x 40A00000 -> %h flags=%b cycles=%0d", result, flags, cyc);
    n_cmp++; if (result !== 32'h41480000) begin n_err++; $display("FAIL abort_next_result got=%h exp=41480000", result); end
    n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL abort_next_latency got=%0d exp=28", cyc); end
  endtask

  task automatic test_step4();
    int cyc;
    A = 32'h40200000;
    B = 32'h40A00000;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        cyc = i;
        break;
      end
    end
    $display("op4 40200000 x 40A00000 -> %h flags=%b cycles=%0d", result4, flags4, cyc);
    n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL step4_latency got=%0d exp=10", cyc); end
    n_cmp++; if (result4 !== 32'h41480000) begin n_err++; $display("FAIL step4_result got=%h exp=41480000", result4); end
    n_cmp++; if (flags4 !== 3'b000) begin n_err++; $display("FAIL step4_flags got=%b exp=000", flags4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_directed();
    test_random();
    test_reset_mid();
    test_step4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
